// File: rtl/led_pulse.sv
// Stretches single-cycle events into LED pulses with a fixed on-time and a minimum off-gap.
// Optional event queue/replay is enabled by defining LED_PULSE_QUEUE_EN.
module led_pulse #(
  parameter int unsigned clk_freq   = 95000,
  parameter int unsigned on_ms      = 50,
  parameter int unsigned off_ms     = 50,
  parameter int unsigned QUEUE_W    = 4,
  parameter bit          active_low = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               event_in,
  output logic               led_out,
  output logic               busy,
  output logic [QUEUE_W-1:0] pending,
  output logic               dropped
);

  localparam int unsigned ON_CYCLES  = on_ms * clk_freq;
  localparam int unsigned OFF_CYCLES = off_ms * clk_freq;
  localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;

`ifdef LED_PULSE_QUEUE_EN
  localparam logic [QUEUE_W-1:0] QUEUE_MAX = '1;
`endif

  // Timer is reloaded only on state entry, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      led_out <= active_low;
      busy    <= 1'b0;
      dropped <= 1'b0;
`ifdef LED_PULSE_QUEUE_EN
      pending <= '0;
`endif
    end else begin
      dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (event_in) begin
            state   <= ON;
            timer   <= ON_LOAD;
            led_out <= ~active_low;
            busy    <= 1'b1;
          end
        end

        ON: begin
          if (timer == '0) begin
            state   <= GAP;
            timer   <= OFF_LOAD;
            led_out <= active_low;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
`ifdef LED_PULSE_QUEUE_EN
          if (event_in) begin
            if (pending == QUEUE_MAX) dropped <= 1'b1;
            else                      pending <= pending + QUEUE_W'(1);
          end
`else
          dropped <= event_in;
`endif
        end

        GAP: begin
          if (timer == '0) begin
`ifdef LED_PULSE_QUEUE_EN
            // A new event at GAP end cancels against a queued one.
            if ((pending != '0) || event_in) begin
              state   <= ON;
              timer   <= ON_LOAD;
              led_out <= ~active_low;
              if (!event_in) pending <= pending - QUEUE_W'(1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
`else
            state   <= IDLE;
            busy    <= 1'b0;
            dropped <= event_in;
`endif
          end else begin
            timer <= timer - TIMER_W'(1);
`ifdef LED_PULSE_QUEUE_EN
            if (event_in) begin
              if (pending == QUEUE_MAX) dropped <= 1'b1;
              else                      pending <= pending + QUEUE_W'(1);
            end
`else
            dropped <= event_in;
`endif
          end
        end

        default: begin
          state   <= IDLE;
          timer   <= '0;
          led_out <= active_low;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifndef LED_PULSE_QUEUE_EN
  assign pending = '0;
`endif

endmodule

// File: tb/tb_led_pulse.sv
// Directed bench for led_pulse with ON_CYCLES=3, OFF_CYCLES=2, QUEUE_W=2.
module tb_led_pulse;

  logic       clk;
  logic       rst;
  logic       event_in;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       dropped;
  logic       led_inv;
  logic       busy_inv;
  logic [1:0] pending_inv;
  logic       dropped_inv;

  int tests;
  int failed;

  led_pulse #(
    .clk_freq(1), .on_ms(3), .off_ms(2), .QUEUE_W(2), .active_low(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .event_in(event_in),
    .led_out(led_out), .busy(busy), .pending(pending), .dropped(dropped)
  );

  led_pulse #(
    .clk_freq(1), .on_ms(3), .off_ms(2), .QUEUE_W(2), .active_low(1'b1)
  ) dut_inv (
    .clk(clk), .rst(rst), .event_in(event_in),
    .led_out(led_inv), .busy(busy_inv), .pending(pending_inv), .dropped(dropped_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; event_in = 1'b1;
    tick(); tick();
    tests++; if (led_out !== 1'b0) begin failed++; $display("FAIL reset_led: got %0b exp 0", led_out); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    tests++; if (pending !== 2'd0) begin failed++; $display("FAIL reset_pending: got %0d exp 0", pending); end
    tests++; if (dropped !== 1'b0) begin failed++; $display("FAIL reset_dropped: got %0b exp 0", dropped); end
    tests++; if (led_inv !== 1'b1) begin failed++; $display("FAIL reset_led_active_low: got %0b exp 1", led_inv); end
    rst = 1'b0; event_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (led_out !== 1'b0 || busy !== 1'b0) begin
        failed++; $display("FAIL reset_no_pulse[%0d]: led=%0b busy=%0b exp 0 0", i, led_out, busy);
      end
    end
  endtask

  task automatic test_single();
    bit exp_led [5]  = '{1, 1, 0, 0, 0};
    bit exp_busy [5] = '{1, 1, 1, 1, 0};
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    tests++; if (led_out !== 1'b1 || busy !== 1'b1) begin
      failed++; $display("FAIL single_start: led=%0b busy=%0b exp 1 1", led_out, busy);
    end
    tests++; if (led_inv !== 1'b0) begin failed++; $display("FAIL single_active_low: got %0b exp 0", led_inv); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (led_out !== exp_led[i] || busy !== exp_busy[i]) begin
        failed++; $display("FAIL single_step[%0d]: led=%0b busy=%0b exp %0b %0b",
                           i, led_out, busy, exp_led[i], exp_busy[i]);
      end
    end
    tick();
  endtask

  task automatic test_mid_reset();
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    tick();
    tests++; if (led_out !== 1'b1) begin failed++; $display("FAIL midrst_on: got %0b exp 1", led_out); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (led_out !== 1'b0 || busy !== 1'b0 || led_inv !== 1'b1) begin
      failed++; $display("FAIL midrst_cut: led=%0b busy=%0b led_inv=%0b exp 0 0 1", led_out, busy, led_inv);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (led_out !== 1'b0 || busy !== 1'b0) begin
        failed++; $display("FAIL midrst_no_resume[%0d]: led=%0b busy=%0b exp 0 0", i, led_out, busy);
      end
    end
  endtask

`ifdef LED_PULSE_QUEUE_EN
  task automatic test_queue();
    bit   exp_led [12] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
    logic [1:0] exp_pend [12] = '{2, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    logic [1:0] exp_fill [3] = '{0, 1, 2};
    for (int i = 0; i < 3; i++) begin
      event_in = 1'b1;
      tick();
      tests++; if (pending !== exp_fill[i] || led_out !== 1'b1) begin
        failed++; $display("FAIL queue_fill[%0d]: pending=%0d led=%0b exp %0d 1", i, pending, led_out, exp_fill[i]);
      end
    end
    event_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      tests++; if (led_out !== exp_led[i] || pending !== exp_pend[i]) begin
        failed++; $display("FAIL queue_replay[%0d]: led=%0b pending=%0d exp %0b %0d",
                           i, led_out, pending, exp_led[i], exp_pend[i]);
      end
    end
    tick();
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL queue_idle: busy=%0b exp 0", busy); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_pend [5] = '{0, 1, 2, 3, 3};
    bit         exp_drop [5] = '{0, 0, 0, 0, 1};
    event_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (pending !== exp_pend[i] || dropped !== exp_drop[i]) begin
        failed++; $display("FAIL sat_step[%0d]: pending=%0d dropped=%0b exp %0d %0b",
                           i, pending, dropped, exp_pend[i], exp_drop[i]);
      end
    end
    event_in = 1'b0;
    tick();
    tests++; if (dropped !== 1'b0 || pending !== 2'd2 || led_out !== 1'b1) begin
      failed++; $display("FAIL sat_after: dropped=%0b pending=%0d led=%0b exp 0 2 1", dropped, pending, led_out);
    end
    for (int i = 0; i < 15; i++) tick();
    tests++; if (busy !== 1'b0 || pending !== 2'd0) begin
      failed++; $display("FAIL sat_drain: busy=%0b pending=%0d exp 0 0", busy, pending);
    end
  endtask

  task automatic test_cancel();
    event_in = 1'b1;
    tick(); tick();
    event_in = 1'b0;
    tests++; if (pending !== 2'd1) begin failed++; $display("FAIL cancel_setup: pending=%0d exp 1", pending); end
    tick(); tick(); tick();
    tests++; if (led_out !== 1'b0 || busy !== 1'b1) begin
      failed++; $display("FAIL cancel_gap: led=%0b busy=%0b exp 0 1", led_out, busy);
    end
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    tests++; if (led_out !== 1'b1 || pending !== 2'd1 || dropped !== 1'b0) begin
      failed++; $display("FAIL cancel_end: led=%0b pending=%0d dropped=%0b exp 1 1 0", led_out, pending, dropped);
    end
    for (int i = 0; i < 5; i++) tick();
    tests++; if (led_out !== 1'b1 || pending !== 2'd0) begin
      failed++; $display("FAIL cancel_replay: led=%0b pending=%0d exp 1 0", led_out, pending);
    end
    for (int i = 0; i < 5; i++) tick();
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL cancel_idle: busy=%0b exp 0", busy); end
  endtask
`else
  task automatic test_drop();
    event_in = 1'b1;
    tick(); tick();
    event_in = 1'b0;
    tests++; if (dropped !== 1'b1 || led_out !== 1'b1 || pending !== 2'd0) begin
      failed++; $display("FAIL drop_on: dropped=%0b led=%0b pending=%0d exp 1 1 0", dropped, led_out, pending);
    end
    tick();
    tests++; if (dropped !== 1'b0 || led_out !== 1'b1) begin
      failed++; $display("FAIL drop_clear: dropped=%0b led=%0b exp 0 1", dropped, led_out);
    end
    tick();
    tests++; if (led_out !== 1'b0 || busy !== 1'b1) begin
      failed++; $display("FAIL drop_gap: led=%0b busy=%0b exp 0 1", led_out, busy);
    end
    tick();
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    tests++; if (dropped !== 1'b1 || busy !== 1'b0 || led_out !== 1'b0) begin
      failed++; $display("FAIL drop_gap_end: dropped=%0b busy=%0b led=%0b exp 1 0 0", dropped, busy, led_out);
    end
    tick();
    tests++; if (dropped !== 1'b0 || busy !== 1'b0 || led_out !== 1'b0) begin
      failed++; $display("FAIL drop_no_second: dropped=%0b busy=%0b led=%0b exp 0 0 0", dropped, busy, led_out);
    end
  endtask
`endif

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    event_in = 1'b0;
    test_reset();
    test_single();
    test_mid_reset();
`ifdef LED_PULSE_QUEUE_EN
    test_queue();
    test_saturation();
    test_cancel();
`else
    test_drop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
